axi_burst_master: RTL

AXI4 burst initiator that turns simple local commands (write/read, address, beat count) into single INCR bursts on an AXI4 master port. It drives memory-side AXI4 slaves such as the single-port memory AXI wrapper and is used by DMA-style engines, BIST/preload controllers and testbenches. Write data enters and read data leaves on valid/ready streams. Completion status is reported per command.

---
 rtl/axi_burst_pkg.sv | 31 +++
 rtl/axi_burst_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI4 burst initiator.
// Holds the FSM state encoding, AXI burst/response codes and a size helper.
// No logic; imported by axi_burst_master.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI AxSIZE encoding: log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size(input int width);
    logic [2:0] sz;
    sz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (width / 8)) sz = i[2:0];
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one local command -> one INCR burst, per-command status.
// Latency: AW/AR valid the cycle after cmd accept; W/R streams zero latency; done 1 cycle after final B/R.
// Backpressure: wr_ready follows wready, rready follows rd_ready; cmd_ready only in IDLE.
// Optional macro AXI_BURST_MASTER_4K_CHECK_EN rejects bursts that cross a 4 KB boundary.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [WIDTH/8-1:0]  wr_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          done_resp,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [WIDTH-1:0]    wdata,
  output logic [WIDTH/8-1:0]  wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [WIDTH-1:0]    rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam int STRB_W = WIDTH / 8;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [1:0]          resp_q;
  logic [1:0]          r_resp_nxt;
  logic [ADDR_W-1:0]   cmd_addr_al;
  logic                cmd_fire;
  logic                w_fire;
  logic                r_fire;
  logic                last_beat;
  logic                cross_4k;

  // Byte address is forced onto a beat boundary.
  assign cmd_addr_al = cmd_addr & ~ADDR_W'(STRB_W - 1);
  assign cmd_fire    = (state_q == ST_IDLE) && cmd_valid;
  assign w_fire      = (state_q == ST_W) && wr_valid && wready;
  assign r_fire      = (state_q == ST_R) && rvalid && rd_ready;
  assign last_beat   = (cnt_q == len_q);

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
  logic [31:0] end_off;
  assign end_off  = 32'(cmd_addr_al[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_W);
  assign cross_4k = (end_off > 32'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  // Fixed AXI attributes and latched address/length.
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = axi_size(WIDTH);
  assign awburst = AXI_BURST_INCR;
  assign awprot  = 3'b000;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = axi_size(WIDTH);
  assign arburst = AXI_BURST_INCR;
  assign arprot  = 3'b000;
  assign wdata   = wr_data;
  assign wstrb   = wr_strb;
  assign rd_data = rdata;

  // Sticky read response: first non-OKAY wins; a missing rlast on the final beat is SLVERR.
  always_comb begin
    r_resp_nxt = (resp_q == AXI_RESP_OKAY) ? rresp : resp_q;
    if (last_beat && !rlast && (r_resp_nxt == AXI_RESP_OKAY)) r_resp_nxt = AXI_RESP_SLVERR;
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Command latch, beat counter and completion status.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      resp_q <= AXI_RESP_OKAY;
    end else begin
      if (cmd_fire) begin
        addr_q <= cmd_addr_al;
        len_q  <= cmd_len;
        cnt_q  <= '0;
        resp_q <= cross_4k ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (w_fire || r_fire) cnt_q <= cnt_q + 8'd1;
      if ((state_q == ST_B) && bvalid) resp_q <= bresp;
      if (r_fire) resp_q <= r_resp_nxt;
    end
  end

  // Next-state and handshake outputs; AW/AR valid come straight from the state flop.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    arvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    rd_valid  = 1'b0;
    rready    = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_resp = AXI_RESP_OKAY;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cross_4k ? ST_DONE : (cmd_write ? ST_AW : ST_AR);
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = ST_W;
      end
      ST_W: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = last_beat;
        if (w_fire && last_beat) state_d = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) state_d = ST_DONE;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        rd_last  = last_beat;
        if (r_fire && last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
